// File: rtl/image_processing_module.sv
// image_processing_module
// Streaming 3x3 Gaussian blur for 8-bit grayscale lines 512 pixels wide.
// Input pixels fill four rotating line buffers. Once three lines are buffered, a
// read pass produces one filtered line through a 3-stage pipeline into a 32-entry
// first-word-fall-through output FIFO. o_intr pulses each time a line buffer is
// released back to the writer.
module image_processing_module (
  input  logic       axi_clk,
  input  logic       axi_reset_n,
  input  logic       i_data_valid,
  input  logic [7:0] i_data,
  output logic       o_data_ready,
  output logic       o_data_valid,
  output logic [7:0] o_data,
  input  logic       i_data_ready,
  output logic       o_intr
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } rd_state_t;

  // Line buffer storage: address = {buffer index, column}
  logic [7:0]  r_line [0:2047];

  // Write side
  logic [1:0]  r_wbuf;
  logic [8:0]  r_wcol;

  // Read side
  rd_state_t   r_state;
  logic [1:0]  r_rbuf;
  logic [8:0]  r_rcol;
  logic        r_intr;

  // Buffered pixel accounting
  logic [11:0] r_count;
  logic        r_ready;

  // Filter pipeline
  logic [7:0]  r_win [0:8];
  logic        r_win_vld;
  logic [11:0] r_sum;
  logic        r_sum_vld;
  logic [7:0]  r_res;
  logic        r_res_vld;

  // Output FIFO
  logic [7:0]  r_fifo [0:31];
  logic [4:0]  r_fifo_wp;
  logic [4:0]  r_fifo_rp;
  logic [5:0]  r_fifo_cnt;

  logic        w_wr;
  logic        w_rd;
  logic        w_pop;
  logic [11:0] w_count_nxt;
  logic [11:0] w_sum;
  logic [8:0]  w_col1;
  logic [8:0]  w_col2;
  logic [1:0]  w_buf1;
  logic [1:0]  w_buf2;

  // A read is held back while the FIFO holds 16 or more entries. The at most
  // 4 reads still in flight behind that limit always find room in 32 entries.
  assign w_wr   = i_data_valid & r_ready;
  assign w_rd   = (r_state == ST_READ) && (r_fifo_cnt < 6'd16);
  assign w_pop  = o_data_valid & i_data_ready;

  // Column and buffer indices wrap naturally through their bit widths
  assign w_col1 = r_rcol + 9'd1;
  assign w_col2 = r_rcol + 9'd2;
  assign w_buf1 = r_rbuf + 2'd1;
  assign w_buf2 = r_rbuf + 2'd2;

  assign o_data_ready = r_ready;
  assign o_data_valid = (r_fifo_cnt != 6'd0);
  assign o_data       = r_fifo[r_fifo_rp];
  assign o_intr       = r_intr;

  // Next buffered-pixel count: +1 per accepted write, -1 per issued read
  always_comb begin
    w_count_nxt = r_count;
    if (w_wr && !w_rd) begin
      w_count_nxt = r_count + 12'd1;
    end else if (!w_wr && w_rd) begin
      w_count_nxt = r_count - 12'd1;
    end else begin
      w_count_nxt = r_count;
    end
  end

  // Count register and input-ready flag, registered from the next count
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      r_count <= 12'd0;
      r_ready <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt < 12'd2048);
    end
  end

  // Write pointer: column advances per pixel; buffer rotates after column 511
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      r_wbuf <= 2'd0;
      r_wcol <= 9'd0;
    end else if (w_wr) begin
      r_wcol <= r_wcol + 9'd1;
      if (r_wcol == 9'd511) begin
        r_wbuf <= r_wbuf + 2'd1;
      end
    end
  end

  // Line buffer write port. RAM contents are not reset.
  always_ff @(posedge axi_clk) begin
    if (w_wr) begin
      r_line[{r_wbuf, r_wcol}] <= i_data;
    end
  end

  // Read FSM: start a pass once three lines are buffered; 512 reads per pass
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      r_state <= ST_IDLE;
      r_rbuf  <= 2'd0;
      r_rcol  <= 9'd0;
      r_intr  <= 1'b0;
    end else begin
      r_intr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_count >= 12'd1536) begin
            r_state <= ST_READ;
          end
        end
        ST_READ: begin
          if (w_rd) begin
            r_rcol <= r_rcol + 9'd1;
            if (r_rcol == 9'd511) begin
              r_intr  <= 1'b1;
              r_rbuf  <= r_rbuf + 2'd1;
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Stage 1: capture the 3x3 window (rows R..R+2, columns k..k+2)
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      r_win_vld <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        r_win[i] <= 8'd0;
      end
    end else begin
      r_win_vld <= w_rd;
      if (w_rd) begin
        r_win[0] <= r_line[{r_rbuf, r_rcol}];
        r_win[1] <= r_line[{r_rbuf, w_col1}];
        r_win[2] <= r_line[{r_rbuf, w_col2}];
        r_win[3] <= r_line[{w_buf1, r_rcol}];
        r_win[4] <= r_line[{w_buf1, w_col1}];
        r_win[5] <= r_line[{w_buf1, w_col2}];
        r_win[6] <= r_line[{w_buf2, r_rcol}];
        r_win[7] <= r_line[{w_buf2, w_col1}];
        r_win[8] <= r_line[{w_buf2, w_col2}];
      end
    end
  end

  // Weighted window sum with kernel [1 2 1; 2 4 2; 1 2 1] (max 4080)
  always_comb begin
    w_sum = 12'd0;
    w_sum = 12'(r_win[0]) + (12'(r_win[1]) << 1) + 12'(r_win[2])
          + (12'(r_win[3]) << 1) + (12'(r_win[4]) << 2) + (12'(r_win[5]) << 1)
          + 12'(r_win[6]) + (12'(r_win[7]) << 1) + 12'(r_win[8]);
  end

  // Stages 2 and 3: register the sum, then the sum divided by 16
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      r_sum     <= 12'd0;
      r_sum_vld <= 1'b0;
      r_res     <= 8'd0;
      r_res_vld <= 1'b0;
    end else begin
      r_sum     <= w_sum;
      r_sum_vld <= r_win_vld;
      r_res     <= 8'(r_sum >> 4);
      r_res_vld <= r_sum_vld;
    end
  end

  // Output FIFO: push filtered pixels, pop on downstream handshake
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      r_fifo_wp  <= 5'd0;
      r_fifo_rp  <= 5'd0;
      r_fifo_cnt <= 6'd0;
      for (int i = 0; i < 32; i++) begin
        r_fifo[i] <= 8'd0;
      end
    end else begin
      if (r_res_vld) begin
        r_fifo[r_fifo_wp] <= r_res;
        r_fifo_wp         <= r_fifo_wp + 5'd1;
      end
      if (w_pop) begin
        r_fifo_rp <= r_fifo_rp + 5'd1;
      end
      if (r_res_vld && !w_pop) begin
        r_fifo_cnt <= r_fifo_cnt + 6'd1;
      end else if (!r_res_vld && w_pop) begin
        r_fifo_cnt <= r_fifo_cnt - 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_image_processing_module.sv
// Self-checking bench for image_processing_module. The host follows the line
// protocol: four lines up front, then one further line per o_intr pulse. Every
// output is compared against a direct 3x3 convolution of the stored image.
module tb_image_processing_module;

  localparam int W    = 512;
  localparam int NMAX = 8;

  logic       axi_clk = 1'b0;
  logic       axi_reset_n = 1'b1;
  logic       i_data_valid = 1'b0;
  logic [7:0] i_data = 8'd0;
  logic       o_data_ready;
  logic       o_data_valid;
  logic [7:0] o_data;
  logic       i_data_ready = 1'b0;
  logic       o_intr;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] img [0:NMAX*W-1];
  int got [0:1023];
  int n_sent;
  int n_out;
  int n_intr;

  image_processing_module dut (
    .axi_clk      (axi_clk),
    .axi_reset_n  (axi_reset_n),
    .i_data_valid (i_data_valid),
    .i_data       (i_data),
    .o_data_ready (o_data_ready),
    .o_data_valid (o_data_valid),
    .o_data       (o_data),
    .i_data_ready (i_data_ready),
    .o_intr       (o_intr)
  );

  always #5 axi_clk = ~axi_clk;

  task automatic chk_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Output n is pass n/512, position k = n%512: centred on line pass+1, column k+1
  function automatic int ref_pix(input int n);
    int p, k, s;
    p = n / W;
    k = n % W;
    s = 0;
    for (int dr = 0; dr < 3; dr++) begin
      for (int dc = 0; dc < 3; dc++) begin
        s += ((dr == 1) ? 2 : 1) * ((dc == 1) ? 2 : 1) * int'(img[(p + dr) * W + (k + dc) % W]);
      end
    end
    return s / 16;
  endfunction

  task automatic do_reset();
    axi_reset_n  = 1'b0;
    i_data_valid = 1'b0;
    i_data       = 8'd0;
    i_data_ready = 1'b0;
    @(negedge axi_clk);
    chk_val("rst_valid", o_data_valid, 0);
    chk_val("rst_data", o_data, 0);
    chk_val("rst_intr", o_intr, 0);
    chk_val("rst_ready", o_data_ready, 0);
    repeat (3) @(posedge axi_clk);
    #1 axi_reset_n = 1'b1;
    @(negedge axi_clk);
    chk_val("rel_ready_before_clk", o_data_ready, 0);
    @(negedge axi_clk);
    chk_val("rel_ready_after_clk", o_data_ready, 1);
    @(posedge axi_clk);
    #1;
  endtask

  // pat: 0 constant 100, 1 impulse at line 1 col 5, 2 random.
  // rmode: 0 always ready, 1 random ready, 2 ready except a 200-cycle stall.
  // abort_at >= 0 stops the session early at that cycle (for mid-stream reset).
  task automatic run_session(input int nlines, input int pat, input int rmode, input int abort_at);
    int total, exp_out, cyc, allowed, prev_intr, extra;
    total   = nlines * W;
    exp_out = (nlines - 2) * W;
    for (int i = 0; i < total; i++) begin
      if (pat == 0) img[i] = 8'd100;
      else if (pat == 1) img[i] = (i == W + 5) ? 8'd255 : 8'd0;
      else img[i] = 8'($urandom_range(0, 255));
    end
    n_sent = 0; n_out = 0; n_intr = 0; cyc = 0; prev_intr = 0;
    while (n_out < exp_out && cyc < 30000 && cyc != abort_at) begin
      allowed = (4 + n_intr) * W;
      if (allowed > total) allowed = total;
      i_data_valid = (n_sent < allowed) && ($urandom_range(0, 3) != 0);
      i_data = (n_sent < total) ? img[n_sent] : 8'd0;
      case (rmode)
        0: i_data_ready = 1'b1;
        1: i_data_ready = ($urandom_range(0, 3) != 0);
        default: i_data_ready = !(cyc >= 2300 && cyc < 2500);
      endcase
      @(negedge axi_clk);
      if (o_intr) begin
        chk_val("intr_not_back_to_back", prev_intr, 0);
        n_intr++;
      end
      prev_intr = int'(o_intr);
      if (i_data_valid && o_data_ready) n_sent++;
      if (o_data_valid && i_data_ready) begin
        chk_val("pix", o_data, ref_pix(n_out));
        if (n_out < 1024) got[n_out] = int'(o_data);
        n_out++;
      end
      @(posedge axi_clk);
      #1;
      cyc++;
    end
    if (abort_at < 0) begin
      chk_val("output_count", n_out, exp_out);
      i_data_valid = 1'b0;
      i_data_ready = 1'b1;
      extra = 0;
      repeat (40) begin
        @(negedge axi_clk);
        if (o_data_valid) extra++;
        if (o_intr) n_intr++;
      end
      chk_val("extra_outputs", extra, 0);
      chk_val("intr_count", n_intr, nlines - 2);
      @(posedge axi_clk);
      #1;
    end
  endtask

  initial begin
    int q, acc, drop, lowcnt, seen, nz;

    do_reset();
    // Constant image: two passes of all-100 output
    run_session(4, 0, 0, -1);

    do_reset();
    // Impulse response
    run_session(4, 1, 1, -1);
    chk_val("imp_p0_k3", got[3], 31);
    chk_val("imp_p0_k4", got[4], 63);
    chk_val("imp_p0_k5", got[5], 31);
    chk_val("imp_p0_k6", got[6], 0);
    chk_val("imp_p1_k3", got[W + 3], 15);
    chk_val("imp_p1_k4", got[W + 4], 31);
    chk_val("imp_p1_k5", got[W + 5], 15);

    // Mid-stream reset, then a fresh random image must come out cleanly
    do_reset();
    run_session(8, 2, 1, 3000);
    do_reset();
    q = 0;
    repeat (100) begin
      @(negedge axi_clk);
      if (o_data_valid || o_intr) q++;
    end
    chk_val("quiet_after_reset", q, 0);
    @(posedge axi_clk);
    #1;
    run_session(8, 2, 1, -1);

    // Output backpressure in the middle of a pass
    do_reset();
    run_session(6, 2, 2, -1);

    // Input-full boundary with outputs blocked
    do_reset();
    i_data_ready = 1'b0;
    i_data = 8'd0;
    acc = 0;
    drop = 0;
    for (int c = 0; c < 4000 && drop == 0; c++) begin
      i_data_valid = 1'b1;
      @(negedge axi_clk);
      if (o_data_ready) acc++;
      else drop = 1;
      @(posedge axi_clk);
      #1;
    end
    chk_val("full_ready_drop", drop, 1);
    chk_val("full_accepted_ge_2048", int'(acc >= 2048), 1);
    chk_val("full_accepted_le_2067", int'(acc <= 2067), 1);
    lowcnt = 0;
    repeat (50) begin
      @(negedge axi_clk);
      if (o_data_ready) lowcnt++;
    end
    chk_val("full_ready_held_low", lowcnt, 0);
    @(posedge axi_clk);
    #1;
    i_data_valid = 1'b0;
    i_data_ready = 1'b1;
    seen = 0;
    nz = 0;
    for (int c = 0; c < 3000 && seen == 0; c++) begin
      @(negedge axi_clk);
      if (o_data_valid && o_data != 8'd0) nz++;
      if (o_intr) seen = 1;
      @(posedge axi_clk);
      #1;
    end
    chk_val("full_pass_done", seen, 1);
    @(negedge axi_clk);
    chk_val("full_ready_back", o_data_ready, 1);
    chk_val("full_zero_outputs", nz, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
